agv_pot_scan_ctrl: RTL and testbench

Conversion scheduler for the AGVPotentio ADC datapath. It periodically scans the enabled potentiometer channels and issues start/done handshakes to the ADC converter core. Each channel's 2^OSR_LOG2 samples are averaged, and one result per channel is pushed to the AXI4-Lite register bank. Configuration comes from the slave registers; results and status return to them.

---
 rtl/agv_pot_pkg.sv | 23 ++
 rtl/agv_pot_scan_ctrl_if.sv | 17 +
 rtl/agv_pot_osr_accum.sv | 28 ++
 rtl/agv_pot_scan_ctrl.sv | 98 +++++++++
 tb/tb_agv_pot_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/agv_pot_pkg.sv
// agv_pot_pkg: shared types, default sizing and channel-pick helper for the pot scan controller
package agv_pot_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, SELECT, START, WAIT_CONV, WRITE} scan_state_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_OSR_LOG2 = 2;
  localparam int CH_W = DEF_NUM_CH > 1 ? $clog2(DEF_NUM_CH) : 1;
  localparam int ACC_W = DEF_DATA_W + DEF_OSR_LOG2;
  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } sel_t;
  function automatic sel_t lowest_set_from(input logic [31:0] mask, input int ptr);
    sel_t s;
    s = '0;
    for (int i = 31; i >= 0; i--)
      if (mask[i] && i >= ptr) begin
        s.found = 1'b1;
        s.idx = 5'(i);
      end
    return s;
  endfunction
endpackage

// File: rtl/agv_pot_scan_ctrl_if.sv
// agv_pot_scan_ctrl_if: converter handshake and register-bank result strobe
interface agv_pot_scan_ctrl_if
  import agv_pot_pkg::*;
#(
  parameter int CH_W = agv_pot_pkg::CH_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              conv_start;
  logic [CH_W-1:0]   conv_ch;
  logic              conv_done;
  logic [DATA_W-1:0] conv_data;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] res_data;
  modport master(output conv_start, conv_ch, res_valid, res_ch, res_data, input conv_done, conv_data);
  modport slave(input conv_start, conv_ch, res_valid, res_ch, res_data, output conv_done, conv_data);
endinterface

// File: rtl/agv_pot_osr_accum.sv
// agv_pot_osr_accum: sums 2^OSR_LOG2 samples; full flags the add that completes the set
module agv_pot_osr_accum #(
  parameter int DATA_W = 12,
  parameter int OSR_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic              full,
  output logic [DATA_W-1:0] avg
);
  localparam int ACC_W = DATA_W + OSR_LOG2;
  logic [ACC_W-1:0]  acc;
  logic [OSR_LOG2:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= acc + ACC_W'(data);
      cnt <= cnt + 1'b1;
    end
  end
  assign full = add && cnt == (OSR_LOG2 + 1)'(2 ** OSR_LOG2 - 1);
  assign avg = DATA_W'(acc >> OSR_LOG2);
endmodule

// File: rtl/agv_pot_scan_ctrl.sv
// agv_pot_scan_ctrl: periodic oversampled scan of enabled pot channels into the register bank
module agv_pot_scan_ctrl
  import agv_pot_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OSR_LOG2 = DEF_OSR_LOG2,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cfg_enable,
  input  logic [NUM_CH-1:0]   cfg_ch_mask,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                err_clr,
  output logic                scan_done,
  output logic                busy,
  output logic                err_timeout,
  agv_pot_scan_ctrl_if.master bus
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  scan_state_t state, state_nx;
  logic [NUM_CH-1:0]   mask_q;
  logic [PERIOD_W-1:0] period_q, pcnt;
  logic [TW-1:0]       tcnt;
  logic [CW:0]         ch_ptr;
  logic [CW-1:0]       ch_q;
  logic [DATA_W-1:0]   avg;
  logic last, timeout, tick_end, go, scan_done_q, err;
  sel_t sel;
  assign sel = lowest_set_from(32'(mask_q), int'(ch_ptr));
  assign go = cfg_enable && |cfg_ch_mask;
  assign tick_end = state == WAIT_TICK && pcnt <= PERIOD_W'(1);
  assign timeout = state == WAIT_CONV && !bus.conv_done && tcnt == TW'(TIMEOUT_CYC - 1);
  agv_pot_osr_accum #(.DATA_W(DATA_W), .OSR_LOG2(OSR_LOG2)) u_accum (
    .clk (ACLK),
    .rst (ARESET),
    .clr (state == SELECT),
    .add (state == WAIT_CONV && bus.conv_done),
    .data(bus.conv_data),
    .full(last),
    .avg (avg)
  );
  always_ff @(posedge ACLK) state <= ARESET ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = go ? SELECT : IDLE;
      WAIT_TICK: state_nx = !tick_end ? WAIT_TICK : go ? SELECT : IDLE;
      SELECT:    state_nx = !cfg_enable ? IDLE : sel.found ? START : WAIT_TICK;
      START:     state_nx = WAIT_CONV;
      WAIT_CONV: state_nx = bus.conv_done ? (!cfg_enable ? IDLE : last ? WRITE : START)
                          : timeout ? (cfg_enable ? SELECT : IDLE) : WAIT_CONV;
      WRITE:     state_nx = SELECT;
      default:   state_nx = IDLE;
    endcase
  end
  // ch_ptr reaching NUM_CH leaves no candidate bit, which ends the scan
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      mask_q <= '0;
      period_q <= '0;
      pcnt <= '0;
      tcnt <= '0;
      ch_ptr <= '0;
      ch_q <= '0;
      scan_done_q <= 1'b0;
      err <= 1'b0;
    end else begin
      scan_done_q <= state == SELECT && cfg_enable && !sel.found;
      if (state == IDLE || tick_end) begin
        mask_q <= cfg_ch_mask;
        period_q <= cfg_period;
        ch_ptr <= '0;
      end
      if (state == SELECT) begin
        pcnt <= period_q;
        if (sel.found) ch_q <= CW'(sel.idx);
      end
      if (state == WAIT_TICK) pcnt <= pcnt - PERIOD_W'(1);
      tcnt <= state == WAIT_CONV ? tcnt + 1'b1 : '0;
      if (state == WRITE || timeout) ch_ptr <= {1'b0, ch_q} + 1'b1;
      err <= timeout || (err && !err_clr);
    end
  end
  always_comb begin
    bus.conv_start = state == START;
    bus.conv_ch = ch_q;
    bus.res_valid = state == WRITE;
    bus.res_ch = state == WRITE ? ch_q : '0;
    bus.res_data = state == WRITE ? avg : '0;
    busy = state != IDLE;
    scan_done = scan_done_q;
    err_timeout = err;
  end
endmodule

// File: tb/tb_agv_pot_scan_ctrl.sv
// tb_agv_pot_scan_ctrl: directed scans against a per-instance result scoreboard and timing model
module tb_agv_pot_scan_ctrl;
  logic clk = 0, rst = 1, err_clr = 0;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] data;
  } res_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sample_of(input int g, input int ch, input int s);
    return g == 0 ? ch * 100 + s : 4095;
  endfunction

  function automatic int model_avg(input int g, input int ch);
    int osr = g == 0 ? 2 : 0, sum = 0;
    for (int s = 0; s < (1 << osr); s++) sum += sample_of(g, ch, s);
    return sum >> osr;
  endfunction

  function automatic int model_gap(input int period);
    return (period == 0 ? 1 : period) + 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int OSR = g == 0 ? 2 : 0;
    logic en = 0;
    logic [3:0] mask = 0, respond = 4'hF;
    logic [15:0] per = 0;
    logic scan_done, busy, err;
    res_t exp_q[$];
    res_t r;
    int n_start = 0, n_scan = 0, n_res = 0, n_busy = 0, last_sd = -1, exp_gap = 0;
    int last_gap = -1, last_data = -1, cch = 0;
    int samp[4] = '{0, 0, 0, 0};
    agv_pot_scan_ctrl_if #(.CH_W(2), .DATA_W(12)) bus ();
    agv_pot_scan_ctrl #(.NUM_CH(4), .DATA_W(12), .OSR_LOG2(OSR), .PERIOD_W(16), .TIMEOUT_CYC(1024)) dut (
      .ACLK(clk), .ARESET(rst), .cfg_enable(en), .cfg_ch_mask(mask), .cfg_period(per),
      .err_clr(err_clr), .scan_done(scan_done), .busy(busy), .err_timeout(err), .bus(bus)
    );
    initial begin
      bus.conv_done = 0;
      bus.conv_data = 0;
      forever begin
        @(negedge clk);
        bus.conv_done = 0;
        bus.conv_data = 0;
        if (bus.conv_start && respond[bus.conv_ch]) begin
          cch = int'(bus.conv_ch);
          repeat (5) @(negedge clk);
          bus.conv_done = 1;
          bus.conv_data = 12'(sample_of(g, cch, samp[cch] % 4));
          samp[cch]++;
        end
      end
    end
    always @(negedge clk) begin
      if (bus.conv_start) begin
        n_start++;
        if (last_sd >= 0) begin
          last_gap = cyc - last_sd;
          chk($sformatf("scan_gap%0d", g), last_gap, exp_gap);
          last_sd = -1;
        end
      end
      if (scan_done) begin
        n_scan++;
        last_sd = cyc;
      end
      if (busy) n_busy++;
      if (bus.res_valid) begin
        n_res++;
        last_data = int'(bus.res_data);
        if (exp_q.size() == 0) chk($sformatf("res_unexpected%0d", g), int'(bus.res_valid), 0);
        else begin
          r = exp_q.pop_front();
          chk($sformatf("res_ch%0d", g), int'(bus.res_ch), int'(r.ch));
          chk($sformatf("res_data%0d", g), int'(bus.res_data), int'(r.data));
        end
      end
    end
  end

  task automatic wait_scans(input int g, input int n);
    int k = 0, seen = 0;
    while (seen < n && k < 20000) begin
      @(negedge clk);
      k++;
      if (g == 0 ? gd[0].scan_done : gd[1].scan_done) seen++;
    end
    chk("scan_wait", seen, n);
  endtask

  task automatic wait_idle(input int g);
    int k = 0;
    while ((g == 0 ? gd[0].busy : gd[1].busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", int'(g == 0 ? gd[0].busy : gd[1].busy), 0);
  endtask

  task automatic push_scans(input int g, input int scans, input logic [3:0] mask, input logic [3:0] resp);
    for (int s = 0; s < scans; s++)
      for (int c = 0; c < 4; c++)
        if (mask[c] && resp[c]) begin
          if (g == 0) gd[0].exp_q.push_back(res_t'{2'(c), 12'(model_avg(0, c))});
          else gd[1].exp_q.push_back(res_t'{2'(c), 12'(model_avg(1, c))});
        end
  endtask

  function automatic int outs0();
    return int'({gd[0].bus.conv_start, gd[0].bus.res_valid, gd[0].scan_done, gd[0].busy,
                 gd[0].err, gd[0].bus.conv_ch, gd[0].bus.res_ch, gd[0].bus.res_data});
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base_s, base_r, base_sc, k, n1;
    repeat (3) @(negedge clk);
    chk("reset_outs0", outs0(), 0);
    chk("reset_outs1", int'({gd[1].bus.conv_start, gd[1].bus.res_valid, gd[1].scan_done, gd[1].busy, gd[1].err}), 0);
    rst = 0;

    // full mask, 4x oversampling, period 10
    base_s = gd[0].n_start;
    gd[0].mask = 4'hF; gd[0].per = 10; gd[0].exp_gap = model_gap(10);
    push_scans(0, 2, 4'hF, 4'hF);
    gd[0].en = 1;
    wait_scans(0, 2);
    gd[0].en = 0;
    wait_idle(0);
    gd[0].last_sd = -1;
    chk("p1_queue", gd[0].exp_q.size(), 0);
    chk("p1_starts", gd[0].n_start - base_s, 2 * 4 * 4);
    chk("p1_lit_data", gd[0].last_data, 301);
    chk("p1_lit_gap", gd[0].last_gap, 11);

    // sparse mask 1010
    base_s = gd[0].n_start;
    gd[0].mask = 4'b1010; gd[0].per = 3; gd[0].exp_gap = model_gap(3);
    push_scans(0, 2, 4'b1010, 4'hF);
    gd[0].en = 1;
    wait_scans(0, 2);
    gd[0].en = 0;
    wait_idle(0);
    gd[0].last_sd = -1;
    chk("p2_queue", gd[0].exp_q.size(), 0);
    chk("p2_starts", gd[0].n_start - base_s, 2 * 2 * 4);
    chk("p2_lit_data", gd[0].last_data, 301);

    // silent converter on ch2 -> timeout
    gd[0].mask = 4'b0111; gd[0].per = 10; gd[0].respond = 4'b1011;
    push_scans(0, 1, 4'b0111, 4'b1011);
    gd[0].en = 1;
    k = 0;
    while (!(gd[0].bus.conv_start && gd[0].bus.conv_ch == 2) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("p3_ch2_start", int'(gd[0].bus.conv_ch), 2);
    k = 0;
    while (!gd[0].err && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("p3_timeout_lat", k, 1025);
    wait_scans(0, 1);
    gd[0].en = 0;
    wait_idle(0);
    gd[0].last_sd = -1;
    gd[0].respond = 4'hF;
    chk("p3_queue", gd[0].exp_q.size(), 0);
    chk("p3_err_set", int'(gd[0].err), 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("p3_err_clr", int'(gd[0].err), 0);

    // enable dropped during ch1's second conversion
    for (int c = 0; c < 4; c++) gd[0].samp[c] = 0;
    base_sc = gd[0].n_scan;
    base_r = gd[0].n_res;
    gd[0].mask = 4'hF; gd[0].per = 10;
    push_scans(0, 1, 4'b0001, 4'hF);
    gd[0].en = 1;
    k = 0;
    n1 = 0;
    while (n1 < 2 && k < 3000) begin
      @(negedge clk);
      k++;
      if (gd[0].bus.conv_start && gd[0].bus.conv_ch == 1) n1++;
    end
    gd[0].en = 0;
    k = 0;
    while (gd[0].busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("p4_drop_lat", k, 6);
    repeat (3) @(negedge clk);
    chk("p4_no_scan_done", gd[0].n_scan - base_sc, 0);
    chk("p4_res_count", gd[0].n_res - base_r, 1);
    chk("p4_queue", gd[0].exp_q.size(), 0);

    // enabled with empty mask
    base_s = gd[0].n_start;
    k = gd[0].n_busy;
    gd[0].mask = 4'h0;
    gd[0].en = 1;
    repeat (1000) @(negedge clk);
    gd[0].en = 0;
    chk("p5_busy", gd[0].n_busy - k, 0);
    chk("p5_starts", gd[0].n_start - base_s, 0);

    // reset in the middle of a conversion
    base_r = gd[0].n_res;
    gd[0].mask = 4'hF;
    gd[0].en = 1;
    k = 0;
    while (!gd[0].bus.conv_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("p6_start_seen", int'(gd[0].bus.conv_start), 1);
    repeat (2) @(negedge clk);
    rst = 1;
    gd[0].en = 0;
    @(negedge clk);
    chk("p6_reset_outs", outs0(), 0);
    rst = 0;
    repeat (12) @(negedge clk);
    chk("p6_no_res", gd[0].n_res - base_r, 0);
    gd[0].last_sd = -1;

    // no oversampling, full-scale data, back-to-back scans
    base_s = gd[1].n_start;
    gd[1].mask = 4'hF; gd[1].per = 0; gd[1].exp_gap = model_gap(0);
    push_scans(1, 2, 4'hF, 4'hF);
    gd[1].en = 1;
    wait_scans(1, 2);
    gd[1].en = 0;
    wait_idle(1);
    chk("p7_queue", gd[1].exp_q.size(), 0);
    chk("p7_starts", gd[1].n_start - base_s, 8);
    chk("p7_lit_data", gd[1].last_data, 4095);
    chk("p7_lit_gap", gd[1].last_gap, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
